// File: rtl/scoreboard.sv
// Package and top module for the OoO scoreboard.
// Allocation is in order, completion is out of order and commit is in order.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   flush_i                 discard every in-flight entry
//   issue_*                 allocation handshake; issue_id_o is the trans_id given out
//   rs1_i/rs2_i             operand lookup; *_busy_o, *_fwd_o, *_data_o give the result
//   wb_i[WriteBackPorts]    writeback from functional units, addressed by trans_id
//   commit_*                head entry contents and the commit handshake

package OoO_pkg;
    parameter int unsigned ScoreboardDepth = 4;
    parameter int unsigned ScoreboardIndex = 2;
    parameter int unsigned WriteBackPorts  = 2;

    typedef enum logic [2:0] {
        FU_NONE,
        FU_LOAD,
        FU_STORE,
        FU_ALU,
        FU_BRANCH,
        FU_MULT,
        FU_CSR
    } fu_e;

    typedef struct packed {
        logic                       valid;
        logic [ScoreboardIndex-1:0] trans_id;
        logic [31:0]                data;
        logic                       ex_valid;
    } writeback_t;
endpackage

module scoreboard
    import OoO_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic [31:0]                issue_pc_i,
    input  fu_e                        issue_fu_i,
    input  logic [4:0]                 issue_rd_i,
    output logic [ScoreboardIndex-1:0] issue_id_o,
    input  logic [4:0]                 rs1_i,
    input  logic [4:0]                 rs2_i,
    output logic                       rs1_busy_o,
    output logic                       rs2_busy_o,
    output logic                       rs1_fwd_o,
    output logic                       rs2_fwd_o,
    output logic [31:0]                rs1_data_o,
    output logic [31:0]                rs2_data_o,
    input  writeback_t                 wb_i [WriteBackPorts],
    output logic                       commit_valid_o,
    input  logic                       commit_ready_i,
    output logic [31:0]                commit_pc_o,
    output fu_e                        commit_fu_o,
    output logic [4:0]                 commit_rd_o,
    output logic [31:0]                commit_data_o,
    output logic                       commit_ex_o,
    output logic [ScoreboardIndex-1:0] commit_id_o
);

    typedef logic [ScoreboardIndex-1:0] id_t;

    localparam logic [ScoreboardIndex:0] Full = ScoreboardDepth[ScoreboardIndex:0];

    logic        valid_q [ScoreboardDepth];
    logic        done_q  [ScoreboardDepth];
    logic        ex_q    [ScoreboardDepth];
    logic [31:0] pc_q    [ScoreboardDepth];
    fu_e         fu_q    [ScoreboardDepth];
    logic [4:0]  rd_q    [ScoreboardDepth];
    logic [31:0] data_q  [ScoreboardDepth];

    id_t                  head_q;
    id_t                  tail_q;
    logic [ScoreboardIndex:0] count_q;

    logic issue_fire;
    logic commit_fire;

    // Ready looks only at the registered count, so a commit in the same
    // cycle never frees a slot for that cycle's issue.
    always_comb begin
        issue_ready_o  = (count_q != Full);
        issue_id_o     = tail_q;
        issue_fire     = issue_valid_i & issue_ready_o;
        commit_valid_o = valid_q[head_q] & done_q[head_q] & ~flush_i;
        commit_fire    = commit_valid_o & commit_ready_i;
    end

    always_comb begin
        commit_pc_o   = '0;
        commit_fu_o   = FU_NONE;
        commit_rd_o   = '0;
        commit_data_o = '0;
        commit_ex_o   = 1'b0;
        commit_id_o   = head_q;
        if (valid_q[head_q]) begin
            commit_pc_o   = pc_q[head_q];
            commit_fu_o   = fu_q[head_q];
            commit_rd_o   = rd_q[head_q];
            commit_data_o = data_q[head_q];
            commit_ex_o   = ex_q[head_q];
        end
    end

    // Statement order matters: later writebacks override earlier ports, and
    // the commit clear overrides any writeback landing on the retiring head.
    // The entry at tail is never valid when an issue fires, so writebacks to
    // it are ignored and cannot collide with the allocation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ScoreboardDepth; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
                ex_q[i]    <= 1'b0;
                pc_q[i]    <= '0;
                fu_q[i]    <= FU_NONE;
                rd_q[i]    <= '0;
                data_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            for (int unsigned i = 0; i < ScoreboardDepth; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (issue_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                ex_q[tail_q]    <= 1'b0;
                pc_q[tail_q]    <= issue_pc_i;
                fu_q[tail_q]    <= issue_fu_i;
                rd_q[tail_q]    <= issue_rd_i;
                tail_q          <= tail_q + 1'b1;
            end
            for (int unsigned p = 0; p < WriteBackPorts; p++) begin
                if (wb_i[p].valid && valid_q[wb_i[p].trans_id]) begin
                    done_q[wb_i[p].trans_id] <= 1'b1;
                    data_q[wb_i[p].trans_id] <= wb_i[p].data;
                    ex_q[wb_i[p].trans_id]   <= wb_i[p].ex_valid;
                end
            end
            if (commit_fire) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            case ({issue_fire, commit_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Operand lookup. Valid entries are contiguous from head, so walking
    // from head outward and keeping the last hit yields the youngest producer.
    logic [4:0]  rs       [2];
    logic        hit      [2];
    id_t         hit_id   [2];
    logic        busy     [2];
    logic        fwd      [2];
    logic [31:0] fwd_data [2];

    always_comb begin
        rs[0] = rs1_i;
        rs[1] = rs2_i;
    end

    always_comb begin
        id_t idx;
        idx = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            hit[s]      = 1'b0;
            hit_id[s]   = '0;
            busy[s]     = 1'b0;
            fwd[s]      = 1'b0;
            fwd_data[s] = '0;
            for (int unsigned i = 0; i < ScoreboardDepth; i++) begin
                idx = head_q + id_t'(i);
                if (rs[s] != '0 && valid_q[idx] && rd_q[idx] == rs[s]) begin
                    hit[s]    = 1'b1;
                    hit_id[s] = idx;
                end
            end
            if (hit[s]) begin
                if (done_q[hit_id[s]]) begin
                    fwd[s]      = 1'b1;
                    fwd_data[s] = data_q[hit_id[s]];
                end else begin
                    // Same-cycle writeback bypass; higher port overrides.
                    for (int unsigned p = 0; p < WriteBackPorts; p++) begin
                        if (wb_i[p].valid && wb_i[p].trans_id == hit_id[s]) begin
                            fwd[s]      = 1'b1;
                            fwd_data[s] = wb_i[p].data;
                        end
                    end
                    busy[s] = ~fwd[s];
                end
            end
        end
    end

    always_comb begin
        rs1_busy_o = busy[0];
        rs2_busy_o = busy[1];
        rs1_fwd_o  = fwd[0];
        rs2_fwd_o  = fwd[1];
        rs1_data_o = fwd_data[0];
        rs2_data_o = fwd_data[1];
    end

endmodule
